// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
//   Eight-entry (2**ADDR_W) general register file with two asynchronous read
//   ports, one synchronous write port and a PC shadow register that samples r0.
//
//   Ports
//     clka          sole clock; all state updates on its rising edge
//     reset_in      asynchronous active-high reset; clears r0..rN and reg0_out
//     clkb          phase-B strobe of the two-phase system; ignored here
//     pc_latch_clk  synchronous enable; loads the pre-edge r0 into reg0_out
//     we_reg_in     synchronous write enable
//     rd_in         write address
//     data_in       write data
//     sr1_in/sr2_in read addresses
//     sr1_out/sr2_out combinational read data (no write-through bypass)
//     reg0_out      PC shadow register
// ---------------------------------------------------------------------------
module reg_file #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clka,
    input  logic              reset_in,
    input  logic              clkb,
    input  logic              pc_latch_clk,
    input  logic              we_reg_in,
    input  logic [ADDR_W-1:0] rd_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] sr1_in,
    input  logic [ADDR_W-1:0] sr2_in,
    output logic [DATA_W-1:0] sr1_out,
    output logic [DATA_W-1:0] sr2_out,
    output logic [DATA_W-1:0] reg0_out
);

    localparam int NUM_REGS = 1 << ADDR_W;

    // Current contents of every register, gathered for the read muxes.
    logic [DATA_W-1:0] regs_rd [NUM_REGS];

    // clkb belongs to the system clocking scheme but carries no function
    // inside this block; it is deliberately left unconnected to any state.
    logic clkb_unused;
    assign clkb_unused = clkb;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_W-1:0] r_q;
            logic [DATA_W-1:0] r_d;

            always_comb begin
                r_d = r_q;
                if (we_reg_in && (rd_in == ADDR_W'(gi))) begin
                    r_d = data_in;
                end
            end

            always_ff @(posedge clka or posedge reset_in) begin
                if (reset_in) begin
                    r_q <= '0;
                end else begin
                    r_q <= r_d;
                end
            end

            assign regs_rd[gi] = r_q;
        end
    endgenerate

    // Reads come straight from the flops, so a same-cycle write to the
    // addressed register only shows up after the clka edge.
    assign sr1_out = regs_rd[sr1_in];
    assign sr2_out = regs_rd[sr2_in];

    // PC shadow: samples r0's flop output, so a write to r0 on the same edge
    // is not seen until a later latch.
    logic [DATA_W-1:0] reg0_q;
    logic [DATA_W-1:0] reg0_d;

    always_comb begin
        reg0_d = reg0_q;
        if (pc_latch_clk) begin
            reg0_d = regs_rd[0];
        end
    end

    always_ff @(posedge clka or posedge reset_in) begin
        if (reset_in) begin
            reg0_q <= '0;
        end else begin
            reg0_q <= reg0_d;
        end
    end

    assign reg0_out = reg0_q;

endmodule

// File: tb/tb_reg_file.sv
// ---------------------------------------------------------------------------
// tb_reg_file
//   Directed self-checking bench for reg_file. Inputs change 1 ns after a
//   rising clka edge (or on the falling edge for mid-cycle cases); outputs
//   are sampled 1 ns after an edge or mid-cycle, never on the edge itself.
// ---------------------------------------------------------------------------
module tb_reg_file;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    logic              clka = 1'b0;
    logic              reset_in = 1'b0;
    logic              clkb = 1'b0;
    logic              pc_latch_clk = 1'b0;
    logic              we_reg_in = 1'b0;
    logic [ADDR_W-1:0] rd_in = '0;
    logic [DATA_W-1:0] data_in = '0;
    logic [ADDR_W-1:0] sr1_in = '0;
    logic [ADDR_W-1:0] sr2_in = '0;
    logic [DATA_W-1:0] sr1_out;
    logic [DATA_W-1:0] sr2_out;
    logic [DATA_W-1:0] reg0_out;

    int check_cnt = 0;
    int error_cnt = 0;

    reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clka        (clka),
        .reset_in    (reset_in),
        .clkb        (clkb),
        .pc_latch_clk(pc_latch_clk),
        .we_reg_in   (we_reg_in),
        .rd_in       (rd_in),
        .data_in     (data_in),
        .sr1_in      (sr1_in),
        .sr2_in      (sr2_in),
        .sr1_out     (sr1_out),
        .sr2_out     (sr2_out),
        .reg0_out    (reg0_out)
    );

    always #5 clka = ~clka;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            error_cnt++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end else begin
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clka);
        #1;
    endtask

    task automatic write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic pc);
        we_reg_in    = 1'b1;
        rd_in        = a;
        data_in      = d;
        pc_latch_clk = pc;
        step();
        we_reg_in    = 1'b0;
        pc_latch_clk = 1'b0;
    endtask

    // Read one register through port 1 (and port 2 on the same address).
    task automatic read_chk(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
        sr1_in = a;
        sr2_in = a;
        #1;
        check_val({tag, "_p1"}, sr1_out, exp);
        check_val({tag, "_p2"}, sr2_out, exp);
    endtask

    // Expected contents after the directed sequence before the reset test.
    logic [DATA_W-1:0] exp_regs [8];

    initial begin
        // Reset with we=0: every register and the shadow read 0.
        #1 reset_in = 1'b1;
        #2;
        for (int i = 0; i < 8; i++) begin
            sr1_in = ADDR_W'(i);
            sr2_in = ADDR_W'(7 - i);
            #1;
            check_val($sformatf("rst_r%0d_p1", i), sr1_out, 0);
            check_val($sformatf("rst_r%0d_p2", 7 - i), sr2_out, 0);
        end
        check_val("rst_reg0_out", reg0_out, 0);
        step();
        @(negedge clka);
        reset_in = 1'b0;
        step();

        // Two back-to-back writes, then read both.
        write(3'd1, 8'd1, 1'b0);
        we_reg_in = 1'b1; rd_in = 3'd2; data_in = 8'd2; sr1_in = 3'd1; sr2_in = 3'd2;
        step();
        we_reg_in = 1'b0;
        check_val("wr2_sr1", sr1_out, 1);
        check_val("wr2_sr2", sr2_out, 2);

        // r0=8, then latch while writing r3.
        write(3'd0, 8'd8, 1'b0);
        check_val("pre_latch_reg0", reg0_out, 0);
        write(3'd3, 8'd3, 1'b1);
        check_val("latch_reg0", reg0_out, 8);
        read_chk("r3_after_latch", 3'd3, 8'd3);
        read_chk("r0_after_latch", 3'd0, 8'd8);

        // we=0 leaves r3 alone.
        we_reg_in = 1'b0; rd_in = 3'd3; data_in = 8'h55;
        step();
        read_chk("we0_r3", 3'd3, 8'd3);

        // No bypass: old value before the edge, new value after.
        we_reg_in = 1'b1; rd_in = 3'd1; data_in = 8'd10; sr1_in = 3'd1;
        #1;
        check_val("nobypass_before", sr1_out, 1);
        step();
        we_reg_in = 1'b0;
        check_val("nobypass_after", sr1_out, 10);

        // Shadow holds across an r0 write when the latch is low.
        write(3'd0, 8'h77, 1'b0);
        check_val("hold_reg0", reg0_out, 8);
        read_chk("r0_77", 3'd0, 8'h77);

        // Same-edge write of r0 with latch: shadow takes the old r0.
        write(3'd0, 8'd8, 1'b0);
        write(3'd0, 8'd5, 1'b1);
        check_val("same_edge_reg0", reg0_out, 8);
        read_chk("same_edge_r0", 3'd0, 8'd5);
        pc_latch_clk = 1'b1;
        step();
        pc_latch_clk = 1'b0;
        check_val("later_latch_reg0", reg0_out, 5);

        // Fill the upper registers and read all back with different port pairs.
        write(3'd4, 8'hA4, 1'b0);
        write(3'd5, 8'hB5, 1'b0);
        write(3'd6, 8'hC6, 1'b0);
        write(3'd7, 8'hFF, 1'b0);
        exp_regs = '{8'd5, 8'd10, 8'd2, 8'd3, 8'hA4, 8'hB5, 8'hC6, 8'hFF};

        // Combinational reads follow address changes with no clock edge.
        @(negedge clka);
        for (int i = 0; i < 8; i++) begin
            sr1_in = ADDR_W'(i);
            sr2_in = ADDR_W'((i + 3) % 8);
            #0.5;
            check_val($sformatf("comb_r%0d_p1", i), sr1_out, exp_regs[i]);
            check_val($sformatf("comb_r%0d_p2", (i + 3) % 8), sr2_out, exp_regs[(i + 3) % 8]);
        end

        // clkb toggling with nothing enabled changes nothing.
        for (int i = 0; i < 6; i++) begin
            #2 clkb = ~clkb;
        end
        step();
        for (int i = 0; i < 8; i++) begin
            read_chk($sformatf("clkb_r%0d", i), ADDR_W'(i), exp_regs[i]);
        end
        check_val("clkb_reg0", reg0_out, 5);

        // Async reset mid-cycle with write and latch requested.
        we_reg_in = 1'b1; pc_latch_clk = 1'b1; rd_in = 3'd3; data_in = 8'd3;
        @(negedge clka);
        reset_in = 1'b1;
        #1;
        check_val("areset_reg0", reg0_out, 0);
        for (int i = 0; i < 8; i++) begin
            sr1_in = ADDR_W'(i);
            #0.5;
            check_val($sformatf("areset_r%0d", i), sr1_out, 0);
        end
        step();
        read_chk("rst_hold_r3", 3'd3, 8'd0);
        check_val("rst_hold_reg0", reg0_out, 0);

        // First edge after reset release performs a normal write.
        @(negedge clka);
        reset_in = 1'b0; we_reg_in = 1'b1; pc_latch_clk = 1'b0; rd_in = 3'd4; data_in = 8'h44;
        step();
        we_reg_in = 1'b0;
        read_chk("post_rst_r4", 3'd4, 8'h44);
        read_chk("post_rst_r3", 3'd3, 8'd0);

        $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1);
    end

endmodule
